// File: rtl/irq_seq_gen.sv
// rtl/irq_seq_gen.sv - table-driven multi-channel interrupt stimulus sequencer
`timescale 1ns/1ps
module irq_seq_gen #(
  parameter int NUM_IRQ = 4,
  parameter int DEPTH   = 16,
  parameter int DLY_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [DLY_W-1:0]           cfg_dly,
  input  logic [NUM_IRQ-1:0]         cfg_val,
  input  logic                       cfg_last,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [NUM_IRQ-1:0]         irq_mode,
  input  logic [NUM_IRQ-1:0]         irq_ack,
  input  logic                       cnt_clr,
  output logic [NUM_IRQ-1:0]         irq,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   entry_idx,
  output logic [NUM_IRQ*CNT_W-1:0]   rise_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [AW-1:0]        entry_idx_q;
  logic [DLY_W-1:0]     timer_q;
  logic [NUM_IRQ-1:0]   irq_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DLY_W-1:0]     tbl_dly_q [DEPTH];
  logic [NUM_IRQ-1:0]   tbl_val_q [DEPTH];
  logic [DEPTH-1:0]     tbl_last_q;

  logic [NUM_IRQ-1:0]   irq_prev_q;
  logic [NUM_IRQ*CNT_W-1:0] cnt_q;

  logic [NUM_IRQ-1:0]   cur_val;
  logic                 cur_last;
  logic [NUM_IRQ-1:0]   irq_hold_d;
  logic [NUM_IRQ-1:0]   irq_apply_d;
  logic [AW-1:0]        next_idx;

  // Entry being played; the final table slot always terminates the sequence.
  assign cur_val  = tbl_val_q[entry_idx_q];
  assign cur_last = tbl_last_q[entry_idx_q] || (entry_idx_q == AW'(DEPTH - 1));
  assign next_idx = entry_idx_q + AW'(1);

  // Latched channels drop on ack; level channels ignore ack.
  assign irq_hold_d  = irq_q & ~(irq_ack & irq_mode);
  // On apply, latched channels OR in the pattern (set beats ack), level channels copy it.
  assign irq_apply_d = (irq_mode & (irq_hold_d | cur_val)) | (~irq_mode & cur_val);

  // Table storage: writable only while idle so playback never sees a torn entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_dly_q[i] <= '0;
        tbl_val_q[i] <= '0;
      end
      tbl_last_q <= '0;
    end else if (cfg_we && (state_q == IDLE)) begin
      tbl_dly_q[cfg_addr]  <= cfg_dly;
      tbl_val_q[cfg_addr]  <= cfg_val;
      tbl_last_q[cfg_addr] <= cfg_last;
    end
  end

  // Playback FSM with registered irq/busy/done/entry_idx outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      entry_idx_q <= '0;
      timer_q     <= '0;
      irq_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          irq_q <= irq_hold_d;
          if (start && !stop) begin
            state_q     <= RUN;
            entry_idx_q <= '0;
            timer_q     <= tbl_dly_q[0];
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            irq_q   <= '0;
            busy_q  <= 1'b0;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - DLY_W'(1);
            irq_q   <= irq_hold_d;
          end else begin
            irq_q <= irq_apply_d;
            if (!cur_last) begin
              entry_idx_q <= next_idx;
              timer_q     <= tbl_dly_q[next_idx];
            end else if (loop_en) begin
              entry_idx_q <= '0;
              timer_q     <= tbl_dly_q[0];
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating per-channel rising-edge counters driven from the registered irq lines.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      irq_prev_q <= irq_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cnt_clr) begin
          cnt_q[i*CNT_W +: CNT_W] <= '0;
        end else if (irq_q[i] && !irq_prev_q[i] &&
                     (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign irq       = irq_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign entry_idx = entry_idx_q;
  assign rise_cnt  = cnt_q;

endmodule

// File: tb/tb_irq_seq_gen.sv
// tb/tb_irq_seq_gen.sv - scoreboard bench for irq_seq_gen
`timescale 1ns/1ps
module tb_irq_seq_gen;
  localparam int NUM_IRQ = 4;
  localparam int DEPTH   = 16;
  localparam int DLY_W   = 16;
  localparam int CNT_W   = 4;
  localparam int AW      = 4;

  localparam int K_IRQ  = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_IDX  = 3;
  localparam int K_CNT0 = 4;
  localparam int K_CNT1 = 5;

  logic                     clk;
  logic                     resetn;
  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [DLY_W-1:0]         cfg_dly;
  logic [NUM_IRQ-1:0]       cfg_val;
  logic                     cfg_last;
  logic                     start;
  logic                     stop;
  logic                     loop_en;
  logic [NUM_IRQ-1:0]       irq_mode;
  logic [NUM_IRQ-1:0]       irq_ack;
  logic                     cnt_clr;
  logic [NUM_IRQ-1:0]       irq;
  logic                     busy;
  logic                     done;
  logic [AW-1:0]            entry_idx;
  logic [NUM_IRQ*CNT_W-1:0] rise_cnt;

  irq_seq_gen #(.NUM_IRQ(NUM_IRQ), .DEPTH(DEPTH), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dly(cfg_dly),
    .cfg_val(cfg_val), .cfg_last(cfg_last), .start(start), .stop(stop), .loop_en(loop_en),
    .irq_mode(irq_mode), .irq_ack(irq_ack), .cnt_clr(cnt_clr), .irq(irq), .busy(busy),
    .done(done), .entry_idx(entry_idx), .rise_cnt(rise_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc_now   = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [31:0] sample(int kind);
    case (kind)
      K_IRQ:   return 32'(irq);
      K_BUSY:  return 32'(busy);
      K_DONE:  return 32'(done);
      K_IDX:   return 32'(entry_idx);
      default: return 32'(rise_cnt[(kind-K_CNT0)*CNT_W +: CNT_W]);
    endcase
  endfunction

  task automatic compare(string tag, logic [31:0] obs, logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Queue an expectation delta edges from now, kept sorted by cycle.
  task automatic expect_at(string tag, int delta, int kind, logic [31:0] val);
    exp_t e;
    int   pos;
    e.tag  = tag;
    e.cyc  = cyc_now + delta;
    e.kind = kind;
    e.val  = val;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
    sb.insert(pos, e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_now++;
    while (sb.size() > 0 && sb[0].cyc <= cyc_now) begin
      e = sb.pop_front();
      compare(e.tag, sample(e.kind), e.val);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(int a, int d, logic [NUM_IRQ-1:0] v, logic l);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_dly  = DLY_W'(d);
    cfg_val  = v;
    cfg_last = l;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_cnt_clr();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_dly = '0; cfg_val = '0;
    cfg_last = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    irq_mode = '0; irq_ack = '0; cnt_clr = 1'b0;

    // Reset state
    run(2);
    expect_at("rst_irq", 1, K_IRQ, 0);
    expect_at("rst_busy", 1, K_BUSY, 0);
    expect_at("rst_done", 1, K_DONE, 0);
    expect_at("rst_idx", 1, K_IDX, 0);
    expect_at("rst_cnt0", 1, K_CNT0, 0);
    step();
    resetn = 1'b1;
    step();

    // 1: single-shot two-entry sequence
    wr(0, 3, 4'b0001, 1'b0);
    wr(1, 0, 4'b0000, 1'b1);
    expect_at("t1_busy_start", 1, K_BUSY, 1);
    expect_at("t1_idx_start", 1, K_IDX, 0);
    expect_at("t1_irq_wait", 4, K_IRQ, 0);
    expect_at("t1_irq_set", 5, K_IRQ, 4'b0001);
    expect_at("t1_idx1", 5, K_IDX, 1);
    expect_at("t1_cnt_pre", 5, K_CNT0, 0);
    expect_at("t1_irq_clr", 6, K_IRQ, 0);
    expect_at("t1_done", 6, K_DONE, 1);
    expect_at("t1_busy_end", 6, K_BUSY, 0);
    expect_at("t1_done_pulse", 7, K_DONE, 0);
    expect_at("t1_cnt", 7, K_CNT0, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    run(7);

    // 2: looping playback, period 5, stopped on an expiry edge
    pulse_cnt_clr();
    loop_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expect_at($sformatf("t2_hi%0d", k), 5 + 5*k, K_IRQ, 4'b0001);
      expect_at($sformatf("t2_lo%0d", k), 6 + 5*k, K_IRQ, 0);
      expect_at($sformatf("t2_nodone%0d", k), 6 + 5*k, K_DONE, 0);
    end
    expect_at("t2_stop_irq", 51, K_IRQ, 0);
    expect_at("t2_stop_busy", 51, K_BUSY, 0);
    expect_at("t2_stop_done", 51, K_DONE, 0);
    expect_at("t2_cnt", 52, K_CNT0, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    run(49);
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    run(2);

    // 3: latched channel 1, ack after the sequence
    irq_mode = 4'b0010;
    wr(0, 1, 4'b0010, 1'b0);
    wr(1, 1, 4'b0000, 1'b0);
    wr(2, 1, 4'b0010, 1'b1);
    expect_at("t3_irq_pre", 2, K_IRQ, 0);
    expect_at("t3_irq_set", 3, K_IRQ, 4'b0010);
    expect_at("t3_irq_val0", 5, K_IRQ, 4'b0010);
    expect_at("t3_irq_hold", 6, K_IRQ, 4'b0010);
    expect_at("t3_done", 7, K_DONE, 1);
    expect_at("t3_irq_idle", 8, K_IRQ, 4'b0010);
    expect_at("t3_irq_ack", 9, K_IRQ, 0);
    expect_at("t3_cnt1", 10, K_CNT1, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    run(7);
    irq_ack = 4'b0010;
    step();
    irq_ack = '0;
    run(2);

    // 3b: ack held throughout; set wins on apply edges
    expect_at("t3b_set_wins0", 3, K_IRQ, 4'b0010);
    expect_at("t3b_ack_clr0", 4, K_IRQ, 0);
    expect_at("t3b_set_wins1", 7, K_IRQ, 4'b0010);
    expect_at("t3b_ack_clr1", 8, K_IRQ, 0);
    expect_at("t3b_cnt1", 9, K_CNT1, 3);
    irq_ack = 4'b0010;
    start = 1'b1;
    step();
    start = 1'b0;
    run(9);
    irq_ack = '0;
    irq_mode = '0;

    // 4: stop on the expiry edge suppresses the pattern and done
    wr(0, 2, 4'b0100, 1'b1);
    expect_at("t4_busy", 3, K_BUSY, 1);
    expect_at("t4_irq_pre", 3, K_IRQ, 0);
    expect_at("t4_irq", 4, K_IRQ, 0);
    expect_at("t4_busy_off", 4, K_BUSY, 0);
    expect_at("t4_nodone", 4, K_DONE, 0);
    expect_at("t4_nodone2", 5, K_DONE, 0);
    expect_at("t4_irq2", 5, K_IRQ, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    run(2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(2);

    // 5: counter saturation, clear, recount
    pulse_cnt_clr();
    wr(0, 0, 4'b0001, 1'b0);
    wr(1, 0, 4'b0000, 1'b1);
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run(44);
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    expect_at("t5_sat", 1, K_CNT0, 15);
    step();
    expect_at("t5_clr", 1, K_CNT0, 0);
    pulse_cnt_clr();
    expect_at("t5_irq", 2, K_IRQ, 4'b0001);
    expect_at("t5_done", 3, K_DONE, 1);
    expect_at("t5_recount", 4, K_CNT0, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    run(5);

    // 6: writes during RUN ignored; reset mid-RUN; replay of cleared table
    wr(0, 4, 4'b0001, 1'b1);
    expect_at("t6_irq_keep", 6, K_IRQ, 4'b0001);
    expect_at("t6_done", 6, K_DONE, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wr(0, 0, 4'b1000, 1'b1);
    run(6);

    loop_en = 1'b1;
    expect_at("t6_loop_irq", 6, K_IRQ, 4'b0001);
    start = 1'b1;
    step();
    start = 1'b0;
    run(6);
    resetn = 1'b0;
    expect_at("t6_rst_irq", 1, K_IRQ, 0);
    expect_at("t6_rst_busy", 1, K_BUSY, 0);
    expect_at("t6_rst_done", 1, K_DONE, 0);
    expect_at("t6_rst_idx", 1, K_IDX, 0);
    expect_at("t6_rst_cnt0", 1, K_CNT0, 0);
    step();
    resetn = 1'b1;
    loop_en = 1'b0;
    step();

    expect_at("t6_clr_busy", 16, K_BUSY, 1);
    expect_at("t6_clr_idx", 16, K_IDX, 15);
    expect_at("t6_clr_nodone", 16, K_DONE, 0);
    expect_at("t6_clr_irq", 16, K_IRQ, 0);
    expect_at("t6_clr_done", 17, K_DONE, 1);
    expect_at("t6_clr_busy_off", 17, K_BUSY, 0);
    expect_at("t6_clr_irq_end", 17, K_IRQ, 0);
    expect_at("t6_clr_done_off", 18, K_DONE, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    run(18);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total_cnt++;
      $error("FAIL %s observed=unchecked expected=%0h (cycle %0d never reached)", e.tag, e.val, e.cyc);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
